// File: rtl/spi_frame_pkg.sv
// Shared constants and types for the SPI frame receiver.
// Frame layout: {rw, addr[6:0], data[7:0]}, MSB first.
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  localparam logic RW_WRITE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Bit counter step that sticks at full scale, so very long
  // frames can never wrap back onto a legal length.
  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Pin synchronizer with previous-value flop and registered
// rise/fall flags, all resetting to the pin's idle level.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  assign level = chain[SYNC_STAGES-1];

  // Shift the pin through the chain and flag level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 16-bit frame receiver: syncs pins, assembles frames
// and emits one write pulse per valid write frame.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              copi_in,
  input  logic              ncs_in,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              rx_busy
);

  logic sclk_rise;
  logic sclk_fall_unused;
  logic sclk_level_unused;

  logic ncs_level;
  logic ncs_rise;
  logic ncs_fall;

  logic copi_level;
  logic copi_rise_unused;
  logic copi_fall_unused;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [CNT_W-1:0]        cnt_q;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk_in),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ncs_in),
    .level (ncs_level),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (copi_in),
    .level (copi_level),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  assign rx_busy = ~ncs_level;

  // Frame FSM: shift bits while selected, judge the frame on deselect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ncs_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            state <= ST_IDLE;
            if (cnt_q == CNT_FRAME) begin
              if (shift_q[FRAME_BITS-1] == RW_WRITE) begin
                frame_valid <= 1'b1;
                frame_addr  <= shift_q[ADDR_W+DATA_W-1:DATA_W];
                frame_data  <= shift_q[DATA_W-1:0];
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise && !ncs_level) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
            cnt_q   <= cnt_inc(cnt_q);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: a frame-level model queues
// expected pulses, a negedge monitor pops and compares them.
module tb_spi_frame_rx;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_in = 1'b0;
  logic       copi_in = 1'b0;
  logic       ncs_in = 1'b1;
  logic       frame_valid;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic       rx_busy;

  spi_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_in     (sclk_in),
    .copi_in     (copi_in),
    .ncs_in      (ncs_in),
    .frame_valid (frame_valid),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [6:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  logic [6:0] hold_a = '0;
  logic [7:0] hold_d = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outcome straight from the frame rules.
  task automatic model(input logic [63:0] v, input int n);
    ev_t e;
    e.a = v[14:8];
    e.d = v[7:0];
    if (n != 16) begin
      e.is_err = 1'b1;
      exp_q.push_back(e);
    end else if (v[15]) begin
      e.is_err = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [63:0] v, input int n,
                      input int ph, input bit start_low);
    model(v, n);
    if (!start_low) ncs_in = 1'b0;
    tick(ph);
    for (int i = n - 1; i >= 0; i--) begin
      copi_in = v[i];
      tick(ph);
      sclk_in = 1'b1;
      tick(ph);
      sclk_in = 1'b0;
    end
    tick(ph);
    chk("rx_busy_in_frame", 32'(rx_busy), 32'd1);
    ncs_in   = 1'b1;
    rise_cyc = cyc;
    copi_in  = 1'b0;
  endtask

  task automatic gap(input int g, input bit toggle);
    if (toggle) begin
      tick(2);
      sclk_in = 1'b1;
      tick(2);
      sclk_in = 1'b0;
    end
    tick(g);
    chk("rx_busy_idle", 32'(rx_busy), 32'd0);
  endtask

  // Monitor: every pulse must match the head of the queue, and
  // addr/data must hold whenever no write pulse is present.
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst_n) begin
      hold_a = '0;
      hold_d = '0;
    end else begin
      if (frame_valid && frame_err) begin
        checks++;
        failures++;
        $display("FAIL both_pulses valid=1 err=1 required one");
      end
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse valid=%0b err=%0b required none",
                   frame_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          chk("pulse_latency", 32'(cyc - rise_cyc),
              32'(SYNC_STAGES + 2));
          if (!e.is_err) begin
            chk("frame_addr", 32'(frame_addr), 32'(e.a));
            chk("frame_data", 32'(frame_data), 32'(e.d));
            hold_a = e.a;
            hold_d = e.d;
          end
        end
      end
      if (!frame_valid) begin
        checks++;
        if (frame_addr !== hold_a || frame_data !== hold_d) begin
          failures++;
          if (failures < 20)
            $display("FAIL hold addr/data=%0h/%0h required %0h/%0h",
                     frame_addr, frame_data, hold_a, hold_d);
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    int t;
    logic [63:0] v;

    tick(3);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_addr", 32'(frame_addr), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    tick(4);

    send(64'h8480, 16, 4, 1'b0);
    gap(6, 1'b0);

    send(64'h81F0, 16, 4, 1'b0);
    gap(4, 1'b0);
    send(64'h02AA, 16, 4, 1'b0);
    gap(6, 1'b0);

    send(64'h7FFF, 15, 3, 1'b0);
    gap(4, 1'b0);
    send(64'h1ABCD, 17, 3, 1'b0);
    gap(4, 1'b0);
    send(64'h0, 0, 3, 1'b0);
    gap(6, 1'b0);
    send(64'hFFFF_0000_8A3C, 48, 2, 1'b0);
    gap(6, 1'b0);

    ncs_in = 1'b0;
    tick(4);
    v = 64'h8355;
    for (int i = 15; i >= 8; i--) begin
      copi_in = v[i];
      tick(4);
      sclk_in = 1'b1;
      tick(4);
      sclk_in = 1'b0;
    end
    rst_n = 1'b0;
    tick(3);
    chk("midrst_addr", 32'(frame_addr), 32'd0);
    chk("midrst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    send(64'h8255, 16, 4, 1'b1);
    gap(6, 1'b0);

    send(64'h8001, 16, 2, 1'b0);
    gap(2, 1'b0);
    send(64'h8102, 16, 2, 1'b0);
    gap(3, 1'b1);
    gap(3, 1'b1);

    repeat (40) begin
      r = int'($urandom_range(0, 9));
      case (r)
        6: n = 0;
        7: n = int'($urandom_range(1, 15));
        8: n = int'($urandom_range(17, 20));
        9: n = 31 + int'($urandom_range(0, 2));
        default: n = 16;
      endcase
      v = {$urandom, $urandom};
      send(v, n, int'($urandom_range(2, 5)), 1'b0);
      gap(int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)));
    end

    t = 0;
    while (exp_q.size() > 0 && t < 50) begin
      tick(1);
      t++;
    end
    tick(8);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
